// File: rtl/dmem_responder_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : dmem_responder_pkg
// Description : Shared defaults, state encoding and helpers for the
//               multi-cycle data-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_responder_pkg;

    // Default geometry and timing of the data memory
    localparam int DMEM_DEPTH   = 1024;
    localparam int DMEM_LATENCY = 4;
    localparam int DMEM_WORD_W  = 32;

    // Responder states
    typedef enum logic {
        DMEM_IDLE = 1'b0,
        DMEM_BUSY = 1'b1
    } dmem_state_e;

    // Latency counter width: it must hold LATENCY-1 and is never narrower than one bit
    function automatic int dmem_cnt_width(input int latency);
        return (latency > 1) ? $clog2(latency) : 1;
    endfunction

endpackage : dmem_responder_pkg
`default_nettype wire

// File: rtl/dmem_array.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : dmem_array
// Description : Synchronous single-port word RAM with write enable and a
//               registered read port. The read register can be cleared so
//               the responder can return zero data on a rejected access.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH = DMEM_DEPTH
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        en_i,
    input  logic                        we_i,
    input  logic                        clr_i,
    input  logic [$clog2(DEPTH)-1:0]    addr_i,
    input  logic [DMEM_WORD_W-1:0]      wdata_i,
    output logic [DMEM_WORD_W-1:0]      rdata_o
);

    // Storage is deliberately not reset so it can map onto block RAM
    logic [DMEM_WORD_W-1:0] mem_q [DEPTH];
    logic [DMEM_WORD_W-1:0] rdata_q;

    // Write port: a store lands in the array on the access edge
    always_ff @(posedge clk_i) begin
        if (en_i && we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read register: updated only by loads, cleared by reset or a rejected access
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (clr_i) begin
            rdata_q <= '0;
        end else if (en_i && !we_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : dmem_array
`default_nettype wire

// File: rtl/dmem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Memory-side responder for the CPU data port. Accepts one
//               load/store at a time, waits a fixed latency, performs the
//               access and returns a one-cycle acknowledge. stall_o holds
//               the CPU MEM stage while a request is pending.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH   = DMEM_DEPTH,
    parameter int LATENCY = DMEM_LATENCY
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_i,
    input  logic                    we_i,
    input  logic [31:0]             addr_i,
    input  logic [DMEM_WORD_W-1:0]  wdata_i,
    output logic                    ack_o,
    output logic [DMEM_WORD_W-1:0]  rdata_o,
    output logic                    err_o,
    output logic                    stall_o
);

    localparam int               AW       = $clog2(DEPTH);
    localparam int               CNT_W    = dmem_cnt_width(LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    dmem_state_e              state_q, state_d;
    logic [CNT_W-1:0]         cnt_q,   cnt_d;
    logic                     we_q,    we_d;
    logic [31:0]              addr_q,  addr_d;
    logic [DMEM_WORD_W-1:0]   wdata_q, wdata_d;
    logic                     ack_q,   ack_d;
    logic                     err_q,   err_d;

    logic                     do_access;
    logic                     misaligned;
    logic                     out_of_range;
    logic                     bad_addr;
    logic                     mem_en;
    logic                     mem_clr;

    // Address checks operate on the captured request, so they are stable
    // for the whole BUSY period and the access edge sees a settled result.
    assign misaligned = |addr_q[1:0];

    generate
        if (AW + 2 < 32) begin : g_range_chk
            assign out_of_range = |addr_q[31:AW+2];
        end else begin : g_range_full
            // The memory spans the whole 32-bit byte space
            assign out_of_range = 1'b0;
        end
    endgenerate

    assign bad_addr = misaligned | out_of_range;

    // Next-state logic: capture in IDLE, count down in BUSY, access at zero
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        do_access = 1'b0;
        case (state_q)
            DMEM_IDLE: begin
                if (req_i) begin
                    we_d    = we_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    cnt_d   = CNT_LOAD;
                    state_d = DMEM_BUSY;
                end
            end
            DMEM_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    do_access = 1'b1;
                    ack_d     = 1'b1;
                    err_d     = bad_addr;
                    state_d   = DMEM_IDLE;
                end
            end
            default: begin
                state_d = DMEM_IDLE;
            end
        endcase
    end

    // State, counter, captured request and registered handshake outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= DMEM_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    // A reset on the access edge aborts the transaction, so the array is
    // gated here as well; a rejected access clears the read data instead.
    assign mem_en  = do_access & ~bad_addr & ~rst_i;
    assign mem_clr = do_access &  bad_addr & ~rst_i;

    dmem_array #(
        .DEPTH   (DEPTH)
    ) u_array (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (mem_en),
        .we_i    (we_q),
        .clr_i   (mem_clr),
        .addr_i  (addr_q[AW+1:2]),
        .wdata_i (wdata_q),
        .rdata_o (rdata_o)
    );

    assign ack_o   = ack_q;
    assign err_o   = err_q;
    assign stall_o = ((state_q == DMEM_IDLE) && req_i) || (state_q == DMEM_BUSY);

endmodule : dmem_responder
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Directed self-checking bench for dmem_responder with one
//               LATENCY=4 instance and one LATENCY=1 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    logic        clk;
    logic        rst;

    logic        req4, we4, ack4, err4, stall4;
    logic [31:0] addr4, wdata4, rdata4;
    logic        req1, we1, ack1, err1, stall1;
    logic [31:0] addr1, wdata1, rdata1;

    int n_checks;
    int n_pass;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(1024), .LATENCY(4)) u_dut4 (
        .clk_i   (clk),
        .rst_i   (rst),
        .req_i   (req4),
        .we_i    (we4),
        .addr_i  (addr4),
        .wdata_i (wdata4),
        .ack_o   (ack4),
        .rdata_o (rdata4),
        .err_o   (err4),
        .stall_o (stall4)
    );

    dmem_responder #(.DEPTH(1024), .LATENCY(1)) u_dut1 (
        .clk_i   (clk),
        .rst_i   (rst),
        .req_i   (req1),
        .we_i    (we1),
        .addr_i  (addr1),
        .wdata_i (wdata1),
        .ack_o   (ack1),
        .rdata_o (rdata1),
        .err_o   (err1),
        .stall_o (stall1)
    );

    task automatic drive_req(input bit d1, input logic r, input logic w,
                             input logic [31:0] a, input logic [31:0] d);
        if (d1) begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end else begin
            req4 = r; we4 = w; addr4 = a; wdata4 = d;
        end
    endtask

    // One transaction: request for one cycle, then watch up to 20 cycles.
    // lat = index of the ack cycle, counting the cycle right after the
    // acceptance edge as 0; stall_cnt = stall cycles before the ack cycle.
    task automatic run_txn(input bit d1, input logic w, input logic [31:0] a,
                           input logic [31:0] d,
                           output int lat, output int stall_cnt,
                           output logic stall_req, output logic stall_ack,
                           output logic [31:0] rd, output logic er);
        lat = -1; stall_cnt = 0; stall_ack = 1'b1; rd = '0; er = 1'b0;
        @(posedge clk); #1;
        drive_req(d1, 1'b1, w, a, d);
        @(negedge clk);
        stall_req = d1 ? stall1 : stall4;
        @(posedge clk); #1;
        drive_req(d1, 1'b0, w, a, d);
        for (int j = 0; j < 20 && lat < 0; j++) begin
            @(negedge clk);
            if ((d1 ? ack1 : ack4) === 1'b1) begin
                lat       = j;
                stall_ack = d1 ? stall1 : stall4;
                rd        = d1 ? rdata1 : rdata4;
                er        = d1 ? err1 : err4;
            end else if ((d1 ? stall1 : stall4) === 1'b1) begin
                stall_cnt++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++; if (ack4 !== 1'b0)    $display("FAIL reset_ack: got %b expected 0", ack4); else n_pass++;
        n_checks++; if (err4 !== 1'b0)    $display("FAIL reset_err: got %b expected 0", err4); else n_pass++;
        n_checks++; if (rdata4 !== 32'h0) $display("FAIL reset_rdata: got %h expected 0", rdata4); else n_pass++;
        n_checks++; if (stall4 !== 1'b0)  $display("FAIL reset_stall: got %b expected 0", stall4); else n_pass++;
        n_checks++; if (ack1 !== 1'b0)    $display("FAIL reset_ack1: got %b expected 0", ack1); else n_pass++;
    endtask

    task automatic test_store_load();
        int lat, sc; logic sr, sa, er; logic [31:0] rd;
        run_txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, lat, sc, sr, sa, rd, er);
        n_checks++; if (lat !== 4)      $display("FAIL st_lat: got %0d expected 4", lat); else n_pass++;
        n_checks++; if (sc !== 4)       $display("FAIL st_stall_cycles: got %0d expected 4", sc); else n_pass++;
        n_checks++; if (sr !== 1'b1)    $display("FAIL st_stall_req: got %b expected 1", sr); else n_pass++;
        n_checks++; if (er !== 1'b0)    $display("FAIL st_err: got %b expected 0", er); else n_pass++;
        n_checks++; if (rd !== 32'h0)   $display("FAIL st_rdata_hold: got %h expected 0", rd); else n_pass++;
        run_txn(1'b0, 1'b0, 32'h10, 32'h0, lat, sc, sr, sa, rd, er);
        n_checks++; if (lat !== 4)      $display("FAIL ld_lat: got %0d expected 4", lat); else n_pass++;
        n_checks++; if (sc !== 4)       $display("FAIL ld_stall_cycles: got %0d expected 4", sc); else n_pass++;
        n_checks++; if (sa !== 1'b0)    $display("FAIL ld_stall_ack: got %b expected 0", sa); else n_pass++;
        n_checks++; if (rd !== 32'hDEADBEEF) $display("FAIL ld_rdata: got %h expected deadbeef", rd); else n_pass++;
        n_checks++; if (er !== 1'b0)    $display("FAIL ld_err: got %b expected 0", er); else n_pass++;
        @(negedge clk);
        n_checks++; if (ack4 !== 1'b0)  $display("FAIL ack_one_cycle: got %b expected 0", ack4); else n_pass++;
    endtask

    task automatic test_errors();
        int lat, sc; logic sr, sa, er; logic [31:0] rd;
        run_txn(1'b0, 1'b0, 32'h12, 32'h0, lat, sc, sr, sa, rd, er);
        n_checks++; if (lat !== 4)      $display("FAIL mis_lat: got %0d expected 4", lat); else n_pass++;
        n_checks++; if (er !== 1'b1)    $display("FAIL mis_err: got %b expected 1", er); else n_pass++;
        n_checks++; if (rd !== 32'h0)   $display("FAIL mis_rdata: got %h expected 0", rd); else n_pass++;
        run_txn(1'b0, 1'b1, 32'h0, 32'hA5A50001, lat, sc, sr, sa, rd, er);
        n_checks++; if (er !== 1'b0)    $display("FAIL w0_err: got %b expected 0", er); else n_pass++;
        run_txn(1'b0, 1'b1, 32'h1000, 32'hFFFFFFFF, lat, sc, sr, sa, rd, er);
        n_checks++; if (er !== 1'b1)    $display("FAIL oor_err: got %b expected 1", er); else n_pass++;
        run_txn(1'b0, 1'b0, 32'h0, 32'h0, lat, sc, sr, sa, rd, er);
        n_checks++; if (rd !== 32'hA5A50001) $display("FAIL oor_word0: got %h expected a5a50001", rd); else n_pass++;
        n_checks++; if (er !== 1'b0)    $display("FAIL oor_load_err: got %b expected 0", er); else n_pass++;
    endtask

    task automatic test_ignored_req();
        int lat, sc; logic sr, sa, er; logic [31:0] rd;
        int n_ack; int ack_at; logic [31:0] ack_data;
        run_txn(1'b0, 1'b1, 32'h20, 32'h00002020, lat, sc, sr, sa, rd, er);
        @(posedge clk); #1;
        drive_req(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
        @(posedge clk); #1;
        n_ack = 0; ack_at = -1; ack_data = '0;
        for (int j = 0; j < 10; j++) begin
            if (j == 1) drive_req(1'b0, 1'b1, 1'b1, 32'h20, 32'h11111111);
            else        drive_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            @(negedge clk);
            if (ack4 === 1'b1) begin
                n_ack++;
                if (ack_at < 0) begin
                    ack_at   = j;
                    ack_data = rdata4;
                end
            end
            @(posedge clk); #1;
        end
        n_checks++; if (n_ack !== 1)    $display("FAIL ign_ack_count: got %0d expected 1", n_ack); else n_pass++;
        n_checks++; if (ack_at !== 4)   $display("FAIL ign_ack_time: got %0d expected 4", ack_at); else n_pass++;
        n_checks++; if (ack_data !== 32'hDEADBEEF) $display("FAIL ign_rdata: got %h expected deadbeef", ack_data); else n_pass++;
        run_txn(1'b0, 1'b0, 32'h20, 32'h0, lat, sc, sr, sa, rd, er);
        n_checks++; if (rd !== 32'h00002020) $display("FAIL ign_no_write: got %h expected 00002020", rd); else n_pass++;
    endtask

    task automatic test_reset_mid_store();
        int lat, sc; logic sr, sa, er; logic [31:0] rd;
        int n_ack;
        run_txn(1'b0, 1'b1, 32'h40, 32'hCAFE0040, lat, sc, sr, sa, rd, er);
        @(posedge clk); #1;
        drive_req(1'b0, 1'b1, 1'b1, 32'h40, 32'h12345678);
        @(posedge clk); #1;
        drive_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (stall4 !== 1'b0) $display("FAIL rst_mid_stall: got %b expected 0", stall4); else n_pass++;
        n_checks++; if (rdata4 !== 32'h0) $display("FAIL rst_mid_rdata: got %h expected 0", rdata4); else n_pass++;
        n_ack = 0;
        for (int j = 0; j < 8; j++) begin
            if (ack4 === 1'b1) n_ack++;
            @(negedge clk);
        end
        n_checks++; if (n_ack !== 0)    $display("FAIL rst_mid_ack: got %0d expected 0", n_ack); else n_pass++;
        run_txn(1'b0, 1'b0, 32'h40, 32'h0, lat, sc, sr, sa, rd, er);
        n_checks++; if (rd !== 32'hCAFE0040) $display("FAIL rst_mid_old: got %h expected cafe0040", rd); else n_pass++;
        n_checks++; if (lat !== 4)      $display("FAIL rst_mid_lat: got %0d expected 4", lat); else n_pass++;
    endtask

    task automatic test_latency1();
        int lat, sc; logic sr, sa, er; logic [31:0] rd;
        run_txn(1'b1, 1'b1, 32'h0, 32'd1, lat, sc, sr, sa, rd, er);
        n_checks++; if (lat !== 1)      $display("FAIL l1_st_lat: got %0d expected 1", lat); else n_pass++;
        n_checks++; if (sc !== 1)       $display("FAIL l1_st_stall: got %0d expected 1", sc); else n_pass++;
        run_txn(1'b1, 1'b1, 32'h4, 32'd2, lat, sc, sr, sa, rd, er);
        run_txn(1'b1, 1'b1, 32'h8, 32'd3, lat, sc, sr, sa, rd, er);
        run_txn(1'b1, 1'b0, 32'h4, 32'h0, lat, sc, sr, sa, rd, er);
        n_checks++; if (lat !== 1)      $display("FAIL l1_ld_lat: got %0d expected 1", lat); else n_pass++;
        n_checks++; if (sc !== 1)       $display("FAIL l1_ld_stall: got %0d expected 1", sc); else n_pass++;
        n_checks++; if (sa !== 1'b0)    $display("FAIL l1_ld_stall_ack: got %b expected 0", sa); else n_pass++;
        n_checks++; if (rd !== 32'd2)   $display("FAIL l1_ld_rdata: got %h expected 2", rd); else n_pass++;
    endtask

    // Cycle 0 is the first request cycle; acks are due in cycles 2, 4, 6
    task automatic test_back_to_back();
        logic exp_ack, exp_stall;
        for (int c = 0; c < 9; c++) begin
            @(posedge clk); #1;
            drive_req(1'b1, (c < 6), 1'b0, (c < 2) ? 32'h0 : (c < 4) ? 32'h4 : 32'h8, 32'h0);
            @(negedge clk);
            exp_ack   = (c == 2) || (c == 4) || (c == 6);
            exp_stall = (c < 6);
            n_checks++; if (ack1 !== exp_ack)     $display("FAIL b2b_ack c%0d: got %b expected %b", c, ack1, exp_ack); else n_pass++;
            n_checks++; if (stall1 !== exp_stall) $display("FAIL b2b_stall c%0d: got %b expected %b", c, stall1, exp_stall); else n_pass++;
            if (exp_ack) begin
                n_checks++;
                if (rdata1 !== 32'(c / 2)) $display("FAIL b2b_rdata c%0d: got %h expected %h", c, rdata1, 32'(c / 2));
                else n_pass++;
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        test_reset();
        test_store_load();
        test_errors();
        test_ignored_req();
        test_reset_mid_store();
        test_latency1();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_dmem_responder
`default_nettype wire
